id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// One-cycle ID->EX latency; mem_stall freezes the stage, ex_flush and load-use insert bubbles.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        ex_flush,
  input  logic        mem_stall,
  output logic        ex_valid,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic        hazard_stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } ex_t;

  ex_t         ex_q, ex_d, id_pkt;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;

  always_comb begin
    id_pkt.valid     = id_valid;
    id_pkt.rs        = id_rs;
    id_pkt.rt        = id_rt;
    id_pkt.rd        = id_rd;
    id_pkt.reg_write = id_reg_write;
    id_pkt.mem_read  = id_mem_read;
    id_pkt.mem_write = id_mem_write;
    id_pkt.alu_src   = id_alu_src;
    id_pkt.alu_op    = id_alu_op;
    id_pkt.rs_data   = id_rs_data;
    id_pkt.rt_data   = id_rt_data;
    id_pkt.imm       = id_imm;
  end

  // A load in EX whose result the ID instruction needs; r0 is never a real dependence.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                    ((ex_q.rd == id_rs) | (id_uses_rt & (ex_q.rd == id_rt)));

  assign hazard_stall = load_use & ~ex_flush & ~mem_stall;

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (mem_stall) begin
      ex_d = ex_q;
    end else if (ex_flush) begin
      ex_d = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end else if (id_valid) begin
      ex_d = id_pkt;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions, expected EX state queued per issue.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt, id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        ex_flush, mem_stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        hazard_stall;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt, rw, mr, mw, as;
    logic [3:0]  op;
    logic [31:0] rsd, rtd, imm;
  } ins_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw, as;
    logic [3:0]  op;
    logic [31:0] rsd, rtd, imm;
  } ex_t;

  typedef struct packed {
    logic        hz;
    ex_t         ex;
    logic [15:0] cnt;
  } exp_t;

  localparam int LOAD = 0, BUB = 1, HOLD = 2;

  exp_t  sb_q[$];
  string nm_q[$];
  ex_t   last_ex;
  int    tests = 0;
  int    fails = 0;

  function automatic ins_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic ur, input logic rw,
                              input logic mr, input logic mw, input logic as,
                              input logic [3:0] op, input logic [31:0] imm);
    ins_t i;
    i.valid = v; i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rt = ur;
    i.rw = rw; i.mr = mr; i.mw = mw; i.as = as; i.op = op;
    i.rsd = 32'h1111_0000 + {27'd0, rs};
    i.rtd = 32'h2222_0000 + {27'd0, rt};
    i.imm = imm;
    return i;
  endfunction

  function automatic ex_t to_ex(input ins_t i);
    ex_t e;
    e.valid = i.valid; e.rs = i.rs; e.rt = i.rt; e.rd = i.rd;
    e.rw = i.rw; e.mr = i.mr; e.mw = i.mw; e.as = i.as; e.op = i.op;
    e.rsd = i.rsd; e.rtd = i.rtd; e.imm = i.imm;
    return e;
  endfunction

  function automatic ex_t cur_ex();
    ex_t e;
    e.valid = ex_valid; e.rs = ex_rs; e.rt = ex_rt; e.rd = ex_rd;
    e.rw = ex_reg_write; e.mr = ex_mem_read; e.mw = ex_mem_write; e.as = ex_alu_src;
    e.op = ex_alu_op; e.rsd = ex_rs_data; e.rtd = ex_rt_data; e.imm = ex_imm;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input ins_t i, input logic fl, input logic ms);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_uses_rt = i.uses_rt;
    id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_alu_src = i.as;
    id_alu_op = i.op; id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm;
    ex_flush = fl; mem_stall = ms;
  endtask

  // Drive one cycle of ID inputs and queue the EX state expected after the next edge.
  task automatic issue(input string nm, input ins_t i, input logic fl, input logic ms,
                       input int kind, input logic hz, input logic [15:0] cnt);
    exp_t e;
    @(negedge clk);
    drive(i, fl, ms);
    e.hz  = hz;
    e.cnt = cnt;
    case (kind)
      LOAD:    e.ex = to_ex(i);
      BUB:     e.ex = '0;
      default: e.ex = last_ex;
    endcase
    last_ex = e.ex;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  initial begin
    exp_t  e;
    string nm;
    logic  hz_s;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        nm   = nm_q.pop_front();
        hz_s = hazard_stall;
        @(posedge clk);
        #1;
        chk({nm, "_hz"},  {127'd0, hz_s}, {127'd0, e.hz});
        chk({nm, "_ex"},  {8'd0, cur_ex()}, {8'd0, e.ex});
        chk({nm, "_cnt"}, {112'd0, stall_count}, {112'd0, e.cnt});
      end
    end
  end

  ins_t ADD3, LW5, ADD6, LW7, RT7N, RT7U, LW0, USE0, LW1, LW2, ADD3B, INV;

  initial begin
    ADD3  = mk(1, 1, 2, 3,  1, 1, 0, 0, 0, 4'h2, 32'h0);
    LW5   = mk(1, 1, 0, 5,  0, 1, 1, 0, 1, 4'h0, 32'h10);
    ADD6  = mk(1, 5, 4, 6,  1, 1, 0, 0, 0, 4'h2, 32'h0);
    LW7   = mk(1, 2, 0, 7,  0, 1, 1, 0, 1, 4'h0, 32'h20);
    RT7N  = mk(1, 3, 7, 8,  0, 1, 0, 0, 1, 4'h3, 32'h4);
    RT7U  = mk(1, 3, 7, 9,  1, 1, 0, 0, 0, 4'h6, 32'h0);
    LW0   = mk(1, 3, 0, 0,  0, 1, 1, 0, 1, 4'h0, 32'h8);
    USE0  = mk(1, 0, 0, 10, 1, 1, 0, 0, 0, 4'h2, 32'h0);
    LW1   = mk(1, 4, 0, 1,  0, 1, 1, 0, 1, 4'h0, 32'h0);
    LW2   = mk(1, 1, 0, 2,  0, 1, 1, 0, 1, 4'h0, 32'h0);
    ADD3B = mk(1, 2, 2, 3,  1, 1, 0, 0, 0, 4'h2, 32'h0);
    INV   = mk(0, 5, 5, 12, 1, 1, 1, 1, 1, 4'hF, 32'hDEAD);
    last_ex = '0;

    rst_n = 1'b0;
    drive(ADD6, 1'b0, 1'b0);
    #12;
    chk("reset_ex",  {8'd0, cur_ex()}, 128'd0);
    chk("reset_cnt", {112'd0, stall_count}, 128'd0);
    chk("reset_hz",  {127'd0, hazard_stall}, 128'd0);
    rst_n = 1'b1;

    issue("normal_add",   ADD3,  0, 0, LOAD, 0, 16'd0);
    issue("lw5",          LW5,   0, 0, LOAD, 0, 16'd0);
    issue("lu_bubble",    ADD6,  0, 0, BUB,  1, 16'd1);
    issue("lu_release",   ADD6,  0, 0, LOAD, 0, 16'd1);
    issue("lw7_a",        LW7,   0, 0, LOAD, 0, 16'd1);
    issue("rt_unused",    RT7N,  0, 0, LOAD, 0, 16'd1);
    issue("lw7_b",        LW7,   0, 0, LOAD, 0, 16'd1);
    issue("rt_used",      RT7U,  0, 0, BUB,  1, 16'd2);
    issue("rt_release",   RT7U,  0, 0, LOAD, 0, 16'd2);
    issue("lw_r0",        LW0,   0, 0, LOAD, 0, 16'd2);
    issue("r0_no_lu",     USE0,  0, 0, LOAD, 0, 16'd2);
    issue("b2b_lw1",      LW1,   0, 0, LOAD, 0, 16'd2);
    issue("b2b_lw2_bub",  LW2,   0, 0, BUB,  1, 16'd3);
    issue("b2b_lw2",      LW2,   0, 0, LOAD, 0, 16'd3);
    issue("b2b_add_bub",  ADD3B, 0, 0, BUB,  1, 16'd4);
    issue("b2b_add",      ADD3B, 0, 0, LOAD, 0, 16'd4);
    issue("invalid_id",   INV,   0, 0, BUB,  0, 16'd4);
    issue("fl_lw5",       LW5,   0, 0, LOAD, 0, 16'd4);
    issue("flush_lu",     ADD6,  1, 0, BUB,  0, 16'd4);
    issue("after_flush",  ADD6,  0, 0, LOAD, 0, 16'd4);
    issue("ms_lw5",       LW5,   0, 0, LOAD, 0, 16'd4);
    for (int k = 0; k < 3; k++)
      issue("memstall_hold", ADD6, 0, 1, HOLD, 0, 16'd4);
    issue("ms_release",   ADD6,  0, 0, BUB,  1, 16'd5);
    issue("ms_load",      ADD6,  0, 0, LOAD, 0, 16'd5);
    issue("ms_over_fl",   LW5,   1, 1, HOLD, 0, 16'd5);

    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;

    issue("sat_lw_a",     LW5,   0, 0, LOAD, 0, 16'hFFFE);
    issue("sat_reach",    ADD6,  0, 0, BUB,  1, 16'hFFFF);
    issue("sat_lw_b",     LW5,   0, 0, LOAD, 0, 16'hFFFF);
    issue("sat_hold",     ADD6,  0, 0, BUB,  1, 16'hFFFF);
    issue("rst_lw",       LW5,   0, 0, LOAD, 0, 16'hFFFF);
    issue("rst_discard",  ADD6,  0, 0, LOAD, 1, 16'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex",  {8'd0, cur_ex()}, 128'd0);
    chk("async_rst_cnt", {112'd0, stall_count}, 128'd0);
    chk("async_rst_hz",  {127'd0, hazard_stall}, 128'd0);
    rst_n = 1'b1;
    issue("post_rst",     ADD6,  0, 0, LOAD, 0, 16'd0);

    for (int k = 0; k < 50 && sb_q.size() > 0; k++) @(posedge clk);
    tests++;
    if (sb_q.size() > 0) begin
      fails++;
      $display("FAIL drain actual=%0d pending expected=0", sb_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
